// File: rtl/spi_rx_pkg.sv
// Shared types and default sizing for the SPI frame receiver slice.
package spi_rx_pkg;
  localparam int SPI_BITS          = 8;
  localparam int DEF_FRAME_BYTES   = 16;
  localparam int DEF_FRAME_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_SHIFT = 2'b01,
    RX_HOLD  = 2'b10
  } rx_state_e;
endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchroniser with an extra stage for rise/fall pulse detection.
module spi_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);
  logic meta_r, sync_r, dly_r;

  // synchroniser chain plus edge-detect delay stage
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      dly_r  <= RST_VAL;
    end else begin
      meta_r <= i_Async;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign o_Level = sync_r;
  assign o_Rise  = sync_r & ~dly_r;
  assign o_Fall  = ~sync_r & dly_r;
endmodule

// File: rtl/spi_frame_rx_slave.sv
// SPI mode-0 slave byte/frame receiver with a dual-port frame buffer.
// Optional MISO echo of the previous byte is enabled by defining SPI_RX_ECHO_EN.
module spi_frame_rx_slave
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BYTES   = DEF_FRAME_BYTES,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
  parameter int ADDR_W        = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_Clk,
  input  logic              i_SPI_MOSI,
  input  logic              i_SPI_CS_n,
  output logic              o_SPI_MISO,
  output logic              o_RX_DV,
  output logic [7:0]        o_RX_Byte,
  output logic              o_Frame_DV,
  output logic              o_Frame_Err,
  input  logic              i_Err_Clr,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data
);
  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic unused_s;

  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_Clk),
    .o_Level(sclk_lvl_s), .o_Rise(sclk_rise_s), .o_Fall(sclk_fall_s));
  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_MOSI),
    .o_Level(mosi_lvl_s), .o_Rise(mosi_rise_s), .o_Fall(mosi_fall_s));
  spi_rx_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_CS_n),
    .o_Level(cs_lvl_s), .o_Rise(cs_rise_s), .o_Fall(cs_fall_s));

  assign unused_s = ^{sclk_lvl_s, sclk_fall_s, mosi_rise_s, mosi_fall_s, cs_lvl_s};

  rx_state_e         state_r, nxt_state_s;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r, byte_s;
  logic [ADDR_W-1:0] wr_idx_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              byte_done_s, short_err_s, ovr_err_s, timeout_s, counting_s;
  logic              rx_dv_r, frame_dv_r, err_r;
  logic [7:0]        rx_byte_r, rd_data_r;
  logic [7:0]        mem_r [0:(2**ADDR_W)-1];

  assign byte_s     = {shift_r[6:0], mosi_lvl_s};
  assign counting_s = (state_r == RX_IDLE) && (wr_idx_r != '0) && !cs_fall_s;
  assign timeout_s  = counting_s && (to_cnt_r == TO_W'(FRAME_TIMEOUT - 1));

  // state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_r <= RX_IDLE;
    else          state_r <= nxt_state_s;
  end

  // next state and per-cycle byte/error events; CS rise outranks a coincident SCLK rise
  always_comb begin
    nxt_state_s = state_r;
    byte_done_s = 1'b0;
    short_err_s = 1'b0;
    ovr_err_s   = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (cs_fall_s) nxt_state_s = RX_SHIFT;
        else           nxt_state_s = RX_IDLE;
      end
      RX_SHIFT: begin
        if (cs_rise_s) begin
          nxt_state_s = RX_IDLE;
          short_err_s = (bit_cnt_r != 3'd0);
        end else if (sclk_rise_s && (bit_cnt_r == LAST_BIT)) begin
          nxt_state_s = RX_HOLD;
          byte_done_s = 1'b1;
        end else begin
          nxt_state_s = RX_SHIFT;
        end
      end
      RX_HOLD: begin
        ovr_err_s = sclk_rise_s;
        if (cs_rise_s) nxt_state_s = RX_IDLE;
        else           nxt_state_s = RX_HOLD;
      end
      default: nxt_state_s = RX_IDLE;
    endcase
  end

  // bit deserialiser, byte outputs, frame index, timeout and sticky error
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_dv_r    <= 1'b0;
      frame_dv_r <= 1'b0;
      wr_idx_r   <= '0;
      to_cnt_r   <= '0;
      err_r      <= 1'b0;
    end else begin
      if ((state_r == RX_IDLE) && cs_fall_s) begin
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'h00;
      end else if ((state_r == RX_SHIFT) && sclk_rise_s && !cs_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= byte_s;
      end
      rx_dv_r    <= byte_done_s;
      frame_dv_r <= byte_done_s && (wr_idx_r == LAST_IDX);
      if (byte_done_s) rx_byte_r <= byte_s;
      if (byte_done_s) wr_idx_r <= (wr_idx_r == LAST_IDX) ? '0 : wr_idx_r + ADDR_W'(1);
      else if (timeout_s) wr_idx_r <= '0;
      to_cnt_r <= (counting_s && !timeout_s) ? to_cnt_r + TO_W'(1) : '0;
      if (short_err_s || ovr_err_s || timeout_s) err_r <= 1'b1;
      else if (i_Err_Clr) err_r <= 1'b0;
    end
  end

  // frame buffer write port; contents intentionally unreset
  always_ff @(posedge i_Clk) begin
    if (byte_done_s) mem_r[wr_idx_r] <= byte_s;
  end

  // registered read port; same-index collision returns the old word
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rd_data_r <= 8'h00;
    else          rd_data_r <= mem_r[i_Rd_Addr];
  end

  assign o_RX_DV     = rx_dv_r;
  assign o_RX_Byte   = rx_byte_r;
  assign o_Frame_DV  = frame_dv_r;
  assign o_Frame_Err = err_r;
  assign o_Rd_Data   = rd_data_r;

`ifdef SPI_RX_ECHO_EN
  logic [7:0] echo_sr_r;
  logic       miso_r;

  // echo shifter: load previous byte at CS fall, advance on each SCLK fall
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      echo_sr_r <= 8'h00;
      miso_r    <= 1'b0;
    end else if (cs_fall_s) begin
      echo_sr_r <= rx_byte_r;
      miso_r    <= rx_byte_r[7];
    end else if (cs_rise_s) begin
      miso_r    <= 1'b0;
    end else if (sclk_fall_s && !cs_lvl_s) begin
      echo_sr_r <= {echo_sr_r[6:0], 1'b0};
      miso_r    <= echo_sr_r[6];
    end
  end

  assign o_SPI_MISO = miso_r;
`else
  assign o_SPI_MISO = 1'b0;
`endif
endmodule

// File: tb/tb_spi_frame_rx_slave.sv
// Randomised self-checking bench for spi_frame_rx_slave against a frame-level model.
module tb_spi_frame_rx_slave;
  logic       i_Clk = 1'b0, i_Rst_L = 1'b0;
  logic       i_SPI_Clk = 1'b0, i_SPI_MOSI = 1'b0, i_SPI_CS_n = 1'b1;
  logic       o_SPI_MISO, o_RX_DV, o_Frame_DV, o_Frame_Err;
  logic [7:0] o_RX_Byte, o_Rd_Data;
  logic       i_Err_Clr = 1'b0;
  logic [3:0] i_Rd_Addr = 4'd0;

  spi_frame_rx_slave dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_SPI_Clk(i_SPI_Clk), .i_SPI_MOSI(i_SPI_MOSI),
    .i_SPI_CS_n(i_SPI_CS_n), .o_SPI_MISO(o_SPI_MISO), .o_RX_DV(o_RX_DV),
    .o_RX_Byte(o_RX_Byte), .o_Frame_DV(o_Frame_DV), .o_Frame_Err(o_Frame_Err),
    .i_Err_Clr(i_Err_Clr), .i_Rd_Addr(i_Rd_Addr), .o_Rd_Data(o_Rd_Data));

  always #5 i_Clk = ~i_Clk;

  int vec = 0, mis = 0;
  int rx_cnt = 0, fdv_cnt = 0, fdv_bad = 0, miso_bad = 0, last_fdv_rx = -1;
  logic [7:0] got_q[$];
  logic [7:0] exp_mem[16];
  int exp_idx = 0;

  // observer: record every byte/frame pulse seen on the outputs
  always @(negedge i_Clk) begin
    if (i_Rst_L) begin
      if (o_RX_DV) begin
        rx_cnt++;
        got_q.push_back(o_RX_Byte);
      end
      if (o_Frame_DV) begin
        fdv_cnt++;
        last_fdv_rx = rx_cnt;
        if (!o_RX_DV) fdv_bad++;
      end
`ifndef SPI_RX_ECHO_EN
      if (o_SPI_MISO !== 1'b0) miso_bad++;
`endif
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // one CS window: nbits MSB-first from val[15:..], capture MISO before each rise
  task automatic spi_xfer(input logic [15:0] val, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    i_SPI_CS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      i_SPI_MOSI = val[15-i];
      wait_clk(8);
      if (i < 8) cap[7-i] = o_SPI_MISO;
      i_SPI_Clk = 1'b1;
      wait_clk(8);
      i_SPI_Clk = 1'b0;
    end
    wait_clk(8);
    i_SPI_CS_n = 1'b1;
    wait_clk(100);
  endtask

  // send a whole byte and advance the frame model
  task automatic send_byte(input logic [7:0] b);
    logic [7:0] cap;
    spi_xfer({b, 8'h00}, 8, cap);
    exp_mem[exp_idx] = b;
    exp_idx = (exp_idx + 1) % 16;
  endtask

  task automatic clear_err();
    i_Err_Clr = 1'b1;
    wait_clk(1);
    i_Err_Clr = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    wait_clk(3);
    vec++; if (o_RX_DV !== 1'b0) begin mis++; $display("FAIL reset_rx_dv got=%b exp=0", o_RX_DV); end
    vec++; if (o_RX_Byte !== 8'h00) begin mis++; $display("FAIL reset_rx_byte got=%h exp=00", o_RX_Byte); end
    vec++; if (o_Frame_DV !== 1'b0) begin mis++; $display("FAIL reset_frame_dv got=%b exp=0", o_Frame_DV); end
    vec++; if (o_Frame_Err !== 1'b0) begin mis++; $display("FAIL reset_frame_err got=%b exp=0", o_Frame_Err); end
    vec++; if (o_Rd_Data !== 8'h00) begin mis++; $display("FAIL reset_rd_data got=%h exp=00", o_Rd_Data); end
    vec++; if (o_SPI_MISO !== 1'b0) begin mis++; $display("FAIL reset_miso got=%b exp=0", o_SPI_MISO); end
    i_Rst_L = 1'b1;
    exp_idx = 0;
    wait_clk(10);
  endtask

  task automatic test_single_frame();
    logic [7:0] sent[$];
    int rx0 = rx_cnt, f0 = fdv_cnt;
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      sent.push_back(8'($urandom));
      send_byte(sent[i]);
    end
    vec++; if (rx_cnt - rx0 != 16) begin mis++; $display("FAIL single_rx_count got=%0d exp=16", rx_cnt - rx0); end
    vec++; if (fdv_cnt - f0 != 1) begin mis++; $display("FAIL single_frame_dv got=%0d exp=1", fdv_cnt - f0); end
    vec++; if (last_fdv_rx != rx0 + 16) begin mis++; $display("FAIL single_frame_dv_pos got=%0d exp=%0d", last_fdv_rx, rx0 + 16); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vec++; if (got_q[i] !== sent[i]) begin mis++; $display("FAIL single_rx_byte[%0d] got=%h exp=%h", i, got_q[i], sent[i]); end
    end
    for (int a = 0; a < 16; a++) begin
      i_Rd_Addr = 4'(a);
      wait_clk(1);
      vec++; if (o_Rd_Data !== exp_mem[a]) begin mis++; $display("FAIL single_read[%0d] got=%h exp=%h", a, o_Rd_Data, exp_mem[a]); end
    end
  endtask

  task automatic test_back_to_back();
    int f0 = fdv_cnt;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    vec++; if (fdv_cnt - f0 != 2) begin mis++; $display("FAIL b2b_frame_dv got=%0d exp=2", fdv_cnt - f0); end
    vec++; if (o_Frame_Err !== 1'b0) begin mis++; $display("FAIL b2b_err got=%b exp=0", o_Frame_Err); end
    for (int a = 0; a < 16; a++) begin
      i_Rd_Addr = 4'(a);
      wait_clk(1);
      vec++; if (o_Rd_Data !== exp_mem[a]) begin mis++; $display("FAIL b2b_read[%0d] got=%h exp=%h", a, o_Rd_Data, exp_mem[a]); end
    end
  endtask

  task automatic test_short_byte();
    logic [7:0] cap;
    int rx0, f0;
    clear_err();
    rx0 = rx_cnt;
    spi_xfer(16'($urandom), 5, cap);
    vec++; if (o_Frame_Err !== 1'b1) begin mis++; $display("FAIL short_err got=%b exp=1", o_Frame_Err); end
    vec++; if (rx_cnt != rx0) begin mis++; $display("FAIL short_no_dv got=%0d exp=%0d", rx_cnt, rx0); end
    f0 = fdv_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    vec++; if (fdv_cnt - f0 != 1) begin mis++; $display("FAIL short_frame_dv got=%0d exp=1", fdv_cnt - f0); end
    for (int a = 0; a < 16; a++) begin
      i_Rd_Addr = 4'(a);
      wait_clk(1);
      vec++; if (o_Rd_Data !== exp_mem[a]) begin mis++; $display("FAIL short_read[%0d] got=%h exp=%h", a, o_Rd_Data, exp_mem[a]); end
    end
  endtask

  task automatic test_timeout();
    int f0;
    clear_err();
    f0 = fdv_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    wait_clk(3900);
    vec++; if (o_Frame_Err !== 1'b0) begin mis++; $display("FAIL timeout_early got=%b exp=0", o_Frame_Err); end
    wait_clk(300);
    vec++; if (o_Frame_Err !== 1'b1) begin mis++; $display("FAIL timeout_err got=%b exp=1", o_Frame_Err); end
    vec++; if (fdv_cnt != f0) begin mis++; $display("FAIL timeout_no_frame got=%0d exp=%0d", fdv_cnt, f0); end
    exp_idx = 0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    vec++; if (fdv_cnt - f0 != 1) begin mis++; $display("FAIL timeout_frame_dv got=%0d exp=1", fdv_cnt - f0); end
    i_Rd_Addr = 4'd0;
    wait_clk(1);
    vec++; if (o_Rd_Data !== exp_mem[0]) begin mis++; $display("FAIL timeout_addr0 got=%h exp=%h", o_Rd_Data, exp_mem[0]); end
  endtask

  task automatic test_overrun_reset();
    logic [7:0] b, cap;
    int rx0;
    clear_err();
    rx0 = rx_cnt;
    b = 8'($urandom);
    spi_xfer({b, 2'($urandom), 6'd0}, 10, cap);
    exp_mem[exp_idx] = b;
    exp_idx = (exp_idx + 1) % 16;
    vec++; if (o_RX_Byte !== b) begin mis++; $display("FAIL overrun_byte got=%h exp=%h", o_RX_Byte, b); end
    vec++; if (o_Frame_Err !== 1'b1) begin mis++; $display("FAIL overrun_err got=%b exp=1", o_Frame_Err); end
    vec++; if (rx_cnt - rx0 != 1) begin mis++; $display("FAIL overrun_dv got=%0d exp=1", rx_cnt - rx0); end
    i_SPI_CS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 4; i++) begin
      i_SPI_MOSI = 1'($urandom);
      wait_clk(8);
      i_SPI_Clk = 1'b1;
      wait_clk(8);
      i_SPI_Clk = 1'b0;
    end
    i_Rst_L = 1'b0;
    i_SPI_CS_n = 1'b1;
    wait_clk(4);
    vec++; if ({o_RX_DV, o_Frame_DV, o_Frame_Err, o_SPI_MISO} !== 4'b0000) begin
      mis++; $display("FAIL midbyte_reset_flags got=%b exp=0000", {o_RX_DV, o_Frame_DV, o_Frame_Err, o_SPI_MISO}); end
    vec++; if ({o_RX_Byte, o_Rd_Data} !== 16'h0000) begin
      mis++; $display("FAIL midbyte_reset_data got=%h exp=0000", {o_RX_Byte, o_Rd_Data}); end
    i_Rst_L = 1'b1;
    exp_idx = 0;
    wait_clk(10);
    rx0 = rx_cnt;
    send_byte(8'hA5);
    vec++; if (o_RX_Byte !== 8'hA5) begin mis++; $display("FAIL after_reset_byte got=%h exp=a5", o_RX_Byte); end
    vec++; if (rx_cnt - rx0 != 1) begin mis++; $display("FAIL after_reset_dv got=%0d exp=1", rx_cnt - rx0); end
    vec++; if (o_Frame_Err !== 1'b0) begin mis++; $display("FAIL after_reset_err got=%b exp=0", o_Frame_Err); end
    i_Rd_Addr = 4'd0;
    wait_clk(1);
    vec++; if (o_Rd_Data !== exp_mem[0]) begin mis++; $display("FAIL after_reset_read got=%h exp=%h", o_Rd_Data, exp_mem[0]); end
  endtask

  task automatic test_miso();
`ifdef SPI_RX_ECHO_EN
    logic [7:0] cap;
    test_reset();
    spi_xfer({8'h12, 8'h00}, 8, cap);
    vec++; if (cap !== 8'h00) begin mis++; $display("FAIL echo_first got=%h exp=00", cap); end
    spi_xfer({8'hDD, 8'h00}, 8, cap);
    vec++; if (cap !== 8'h12) begin mis++; $display("FAIL echo_second got=%h exp=12", cap); end
`else
    vec++; if (miso_bad != 0) begin mis++; $display("FAIL miso_tied got=%0d exp=0", miso_bad); end
`endif
    vec++; if (fdv_bad != 0) begin mis++; $display("FAIL frame_dv_align got=%0d exp=0", fdv_bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_byte();
    test_timeout();
    test_overrun_reset();
    test_miso();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx_slave.md
Name: spi_frame_rx_slave

Overview:
SPI mode-0 slave receiver: the far end of the FFT result link driven by the SPI master with its single per-byte CS. Deserialises bytes MSB-first, groups FRAME_BYTES bytes into one frame (out_0_re, out_0_im … out_7_im order) and stores them in a small frame buffer. Exposes a per-byte strobe, a frame-complete strobe and a registered random-access read port. Used on the receiving board and as the loopback checker in the FFT bench.

Parameters:
FRAME_BYTES, 16, bytes per frame; write index wraps after FRAME_BYTES-1.
FRAME_TIMEOUT, 4096, i_Clk cycles with CS high and a partial frame before the frame index resyncs to 0.
ADDR_W, 4, read/write index width; must satisfy 2**ADDR_W >= FRAME_BYTES.

Ports:
i_Clk  in  1  system clock; all logic is synchronous to it.
i_Rst_L  in  1  reset; asynchronous, active-low.
i_SPI_Clk  in  1  SCLK from the master, asynchronous to i_Clk.
i_SPI_MOSI  in  1  serial data, MSB first.
i_SPI_CS_n  in  1  chip select, active-low, framing one byte.
o_SPI_MISO  out  1  0 unless SPI_RX_ECHO_EN is defined.
o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid.
o_RX_Byte  out  8  last complete byte; holds its value until the next byte.
o_Frame_DV  out  1  one-cycle pulse when byte FRAME_BYTES-1 has been written.
o_Frame_Err  out  1  sticky; set on short byte, overrun or timeout; cleared by reset or i_Err_Clr.
i_Err_Clr  in  1  clears o_Frame_Err.
i_Rd_Addr  in  ADDR_W  frame buffer read index.
o_Rd_Data  out  8  buffer[i_Rd_Addr], registered; 1-cycle latency.

Behaviour:
- Sync: SCLK, MOSI and CS each pass through 2-FF synchronisers, then 1 extra register for edge detection. SCLK high and low times must each be >= 3 i_Clk periods.
- Sampling: MOSI is sampled on the synchronised SCLK rising edge, in states RX_SHIFT only.
- RX_IDLE -> RX_SHIFT on the CS falling edge: bit_cnt=0, shift reg cleared.
- RX_SHIFT: each SCLK rise shifts {sr[6:0],mosi} and increments bit_cnt.
  - On the 8th rise: o_RX_Byte<=byte; o_RX_DV=1 next cycle; buffer[wr_idx]<=byte; go to RX_HOLD.
- RX_HOLD: further SCLK rises are ignored and set o_Frame_Err (overrun). CS rise -> RX_IDLE.
- CS rise in RX_SHIFT with bit_cnt != 0: byte discarded, o_Frame_Err set, wr_idx unchanged, -> RX_IDLE. CS rise with bit_cnt == 0 goes to RX_IDLE silently.
- wr_idx: increments after each byte write.
  - On the write at index FRAME_BYTES-1: wr_idx<=0 and o_Frame_DV pulses in the same cycle as o_RX_DV.
- Timeout: counter runs while in RX_IDLE with wr_idx != 0 and reloads on any CS fall. On reaching FRAME_TIMEOUT: wr_idx<=0, o_Frame_Err set, no o_Frame_DV.
- Read port: dual-port; a write and a read to the same index in one cycle return the old data.
- i_Err_Clr and a new error in the same cycle: set wins.
- Reset (any time, including mid-byte): state RX_IDLE, wr_idx 0, bit_cnt 0, o_RX_Byte 8'h00, o_RX_DV/o_Frame_DV/o_Frame_Err 0, o_Rd_Data 8'h00, o_SPI_MISO 0.
  - Buffer contents are undefined after reset; the synchroniser FFs reset CS to 1 and SCLK to 0.

Optional Feature:
SPI_RX_ECHO_EN
- Defined: o_SPI_MISO shifts out the previously received byte MSB-first, mode 0.
  - Bit 7 is driven at the CS fall; the next bit follows each synchronised SCLK fall.
  - Driven 0 while CS is high. The echo byte is 8'h00 after reset.
- Not defined: o_SPI_MISO is tied to 0 and the MISO shift register is not generated.

Decomposition:
- Package spi_rx_pkg: state encoding localparams (RX_IDLE=2'b00, RX_SHIFT=2'b01, RX_HOLD=2'b10), SPI_BITS=8, and the default FRAME_BYTES and FRAME_TIMEOUT.
- One sub-module, spi_rx_sync: the 2-FF synchroniser plus edge detector, instantiated 3 times. It outputs a level, a rise pulse and a fall pulse.
- Frame buffer is inferred dual-port RAM in the top module.

Test Plan:
- Single frame: master sends 16 bytes 8'h00,8'h6B,…,8'h54, one CS per byte, 100-clock gaps.
  - Response: 16 o_RX_DV pulses; o_Frame_DV pulses with byte 15.
  - Reading addr 0..15 returns the same sequence 1 cycle after each address.
- Back-to-back frames: 32 bytes sent.
  - Response: two o_Frame_DV pulses; buffer holds the second frame; o_Frame_Err=0.
- Short byte: CS deasserted after 5 SCLK edges, then 16 valid bytes.
  - Response: o_Frame_Err=1; no o_RX_DV for the partial byte; frame completes normally.
- Timeout: 7 bytes, then CS idle for 4096+ clocks, then 16 bytes.
  - Response: o_Frame_Err=1; exactly one o_Frame_DV; addr 0 holds the first byte of the new burst.
- Overrun and reset mid-byte:
  - 10 SCLK edges in one CS: o_RX_Byte equals the first 8 bits and o_Frame_Err=1.
  - i_Rst_L low at bit 4: all outputs are at reset values; the next byte 8'hA5 is received correctly.
- Echo (SPI_RX_ECHO_EN): send 8'h12 then 8'hDD. MISO carries 8'h00 during the first byte and 8'h12 during the second.
